// File: rtl/pipe_hazard_ctl_if.sv
// Hazard-control bundle between the five-stage pipeline and pipe_hazard_ctl.
// The controller takes the slave view; the pipeline datapath takes the master view.
interface pipe_hazard_ctl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rt;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       md_start;
    logic       mem_branch_taken;
    logic       pc_hold;
    logic       ifid_hold;
    logic       ifid_zero;
    logic       idex_hold;
    logic       idex_zero;
    logic       exmem_zero;
    logic       md_busy;
    logic       md_done;

    modport master (
        output id_rs, id_rt, id_use_rt, ex_memread, ex_rt, md_start, mem_branch_taken,
        input  pc_hold, ifid_hold, ifid_zero, idex_hold, idex_zero, exmem_zero,
               md_busy, md_done
    );

    modport slave (
        input  id_rs, id_rt, id_use_rt, ex_memread, ex_rt, md_start, mem_branch_taken,
        output pc_hold, ifid_hold, ifid_zero, idex_hold, idex_zero, exmem_zero,
               md_busy, md_done
    );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Stall/flush controller: branch flush, multi-cycle mult/div freeze and load-use bubble.
// Outputs are combinational from {state, count, inputs}; only the mult/div sequencer is registered.
module pipe_hazard_ctl #(
    parameter int MD_CYCLES = 32,
    parameter int CW        = 6
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctl_if.slave hz
);
    typedef enum logic {S_RUN, S_BUSY} state_t;

    localparam logic [CW-1:0] LP_CNT_INIT = CW'(MD_CYCLES - 2);

    state_t        r_state;
    logic [CW-1:0] r_cnt;

    logic w_load_use;
    logic w_pc_hold, w_ifid_hold, w_ifid_zero, w_idex_hold, w_idex_zero, w_exmem_zero;
    logic w_md_busy, w_md_done;

    // Register $0 is hard-wired, so a load into it never blocks a consumer.
    assign w_load_use = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                        ((hz.ex_rt == hz.id_rs) || (hz.id_use_rt && (hz.ex_rt == hz.id_rt)));

    always_comb begin
        w_pc_hold    = 1'b0;
        w_ifid_hold  = 1'b0;
        w_ifid_zero  = 1'b0;
        w_idex_hold  = 1'b0;
        w_idex_zero  = 1'b0;
        w_exmem_zero = 1'b0;
        w_md_busy    = (r_state == S_BUSY) && !rst;
        w_md_done    = 1'b0;
        if (rst || hz.mem_branch_taken) begin
            w_ifid_zero  = 1'b1;
            w_idex_zero  = 1'b1;
            w_exmem_zero = 1'b1;
        end else if (r_state == S_BUSY) begin
            if (r_cnt != '0) begin
                w_pc_hold    = 1'b1;
                w_ifid_hold  = 1'b1;
                w_idex_hold  = 1'b1;
                w_exmem_zero = 1'b1;
            end else begin
                w_md_done = 1'b1;
            end
        end else if (hz.md_start) begin
            w_pc_hold    = 1'b1;
            w_ifid_hold  = 1'b1;
            w_idex_hold  = 1'b1;
            w_exmem_zero = 1'b1;
        end else if (w_load_use) begin
            w_pc_hold   = 1'b1;
            w_ifid_hold = 1'b1;
            w_idex_zero = 1'b1;
        end
    end

    // A taken branch squashes the younger mult/div op exactly like reset does.
    always_ff @(posedge clk) begin
        if (rst || hz.mem_branch_taken) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else if (r_state == S_BUSY) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_state <= S_RUN;
            end
        end else if (hz.md_start) begin
            r_state <= S_BUSY;
            r_cnt   <= LP_CNT_INIT;
        end
    end

    assign hz.pc_hold    = w_pc_hold;
    assign hz.ifid_hold  = w_ifid_hold;
    assign hz.ifid_zero  = w_ifid_zero;
    assign hz.idex_hold  = w_idex_hold;
    assign hz.idex_zero  = w_idex_zero;
    assign hz.exmem_zero = w_exmem_zero;
    assign hz.md_busy    = w_md_busy;
    assign hz.md_done    = w_md_done;
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: two instances (MD_CYCLES=4 and 2) share directed and random stimulus
// and are compared each cycle against a remaining-cycles reference model.
module tb_pipe_hazard_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_hazard_ctl_if if4 ();
    pipe_hazard_ctl_if if2 ();

    pipe_hazard_ctl #(.MD_CYCLES(4), .CW(6)) u_md4 (.clk(clk), .rst(rst), .hz(if4.slave));
    pipe_hazard_ctl #(.MD_CYCLES(2), .CW(6)) u_md2 (.clk(clk), .rst(rst), .hz(if2.slave));

    always #5 clk = ~clk;

    // Output vector order: {pc_hold, ifid_hold, ifid_zero, idex_hold, idex_zero, exmem_zero, md_busy, md_done}
    logic [7:0] w_obs4, w_obs2;
    assign w_obs4 = {if4.pc_hold, if4.ifid_hold, if4.ifid_zero, if4.idex_hold,
                     if4.idex_zero, if4.exmem_zero, if4.md_busy, if4.md_done};
    assign w_obs2 = {if2.pc_hold, if2.ifid_hold, if2.ifid_zero, if2.idex_hold,
                     if2.idex_zero, if2.exmem_zero, if2.md_busy, if2.md_done};

    localparam logic [7:0] O_IDLE   = 8'b0000_0000;
    localparam logic [7:0] O_FLUSH  = 8'b0010_1100;
    localparam logic [7:0] O_LDUSE  = 8'b1100_1000;
    localparam logic [7:0] O_MDSTRT = 8'b1101_0100;
    localparam logic [7:0] O_MDWAIT = 8'b1101_0110;
    localparam logic [7:0] O_MDDONE = 8'b0000_0011;

    int n_chk = 0;
    int n_err = 0;
    int left4 = 0;
    int left2 = 0;

    task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // left = EX cycles still owed by the current mult/div op after this cycle's start.
    function automatic logic [7:0] ref_out(input int left, input bit r, input bit br,
                                           input bit st, input bit lu);
        if (r)         return O_FLUSH;
        if (br)        return O_FLUSH | {6'b0, (left > 0), 1'b0};
        if (left > 1)  return O_MDWAIT;
        if (left == 1) return O_MDDONE;
        if (st)        return O_MDSTRT;
        if (lu)        return O_LDUSE;
        return O_IDLE;
    endfunction

    function automatic int ref_next(input int md, input int left, input bit r,
                                    input bit br, input bit st);
        if (r || br)  return 0;
        if (left > 0) return left - 1;
        if (st)       return md - 1;
        return 0;
    endfunction

    task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                        input bit mr, input logic [4:0] ert, input bit st, input bit br,
                        input string tag);
        bit lu;
        @(negedge clk);
        rst = r;
        if4.id_rs = rs;  if4.id_rt = rt;  if4.id_use_rt = urt;  if4.ex_memread = mr;
        if4.ex_rt = ert; if4.md_start = st; if4.mem_branch_taken = br;
        if2.id_rs = rs;  if2.id_rt = rt;  if2.id_use_rt = urt;  if2.ex_memread = mr;
        if2.ex_rt = ert; if2.md_start = st; if2.mem_branch_taken = br;
        #1;
        lu = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
        chk_eq({tag, "/m4"}, w_obs4, ref_out(left4, r, br, st, lu));
        chk_eq({tag, "/m2"}, w_obs2, ref_out(left2, r, br, st, lu));
        left4 = ref_next(4, left4, r, br, st);
        left2 = ref_next(2, left2, r, br, st);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, tag);
    endtask

    function automatic logic [4:0] rnd_reg();
        logic [4:0] v;
        v = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
        return v;
    endfunction

    initial begin
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "rst0");
        chk_eq("rst0_lit", w_obs4, O_FLUSH);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "rst1");
        chk_eq("rst1_lit", w_obs4, O_FLUSH);
        idle("post_rst");
        chk_eq("post_rst_lit", w_obs4, O_IDLE);

        step(1'b0, 5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, "lu_rs");
        chk_eq("lu_rs_lit", w_obs4, O_LDUSE);
        step(1'b0, 5'd8, 5'd1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, "lu_gone");
        chk_eq("lu_gone_lit", w_obs4, O_IDLE);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, "lu_r0");
        chk_eq("lu_r0_lit", w_obs4, O_IDLE);
        step(1'b0, 5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, "lu_rt_nouse");
        chk_eq("lu_rt_nouse_lit", w_obs4, O_IDLE);
        step(1'b0, 5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, "lu_rt_use");
        chk_eq("lu_rt_use_lit", w_obs4, O_LDUSE);

        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "md_T0");
        chk_eq("md4_T0", w_obs4, O_MDSTRT);
        chk_eq("md2_T0", w_obs2, O_MDSTRT);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "md_T1");
        chk_eq("md4_T1", w_obs4, O_MDWAIT);
        chk_eq("md2_T1", w_obs2, O_MDDONE);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "md_T2");
        chk_eq("md4_T2", w_obs4, O_MDWAIT);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "md_T3");
        chk_eq("md4_T3", w_obs4, O_MDDONE);
        idle("md_after0");
        idle("md_after1");
        idle("md_after2");
        chk_eq("md_after_lit", w_obs4, O_IDLE);

        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "br_T0");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, "br_T1");
        chk_eq("br_T1_lit", w_obs4, O_FLUSH | 8'b0000_0010);
        idle("br_T2");
        chk_eq("br_T2_lit", w_obs4, O_IDLE);
        idle("br_T3");
        chk_eq("br_T3_lit", w_obs4, O_IDLE);

        step(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, "prio");
        chk_eq("prio_lit", w_obs4, O_FLUSH);

        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "rstmid_T0");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "rstmid_T1");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "rstmid_T2");
        chk_eq("rstmid_lit", w_obs4, O_FLUSH);
        idle("rstmid_T3");
        chk_eq("rstmid_T3_lit", w_obs4, O_IDLE);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0), rnd_reg(), rnd_reg(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rnd_reg(), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 11) == 0), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
- Central stall/flush controller for the five-stage pipeline.
- Drives the hold and zero controls of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers (zero = flush to bubble, hold = keep current value).
- Detects load-use hazards and taken branches resolved in MEM.
- Sequences a multi-cycle multiply/divide unit in EX by freezing the front end for a fixed number of cycles.

Parameters:
- MD_CYCLES, 32: total cycles a mult/div op occupies EX; legal range 2..2^CW.
- CW, 6: width of the internal mult/div down-counter.

Ports:
- clk  input  1  pipeline clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_use_rt  input  1  instruction in ID reads rt as a source.
- ex_memread  input  1  instruction in EX is a load.
- ex_rt  input  5  destination (rt) of the instruction in EX.
- md_start  input  1  instruction in EX is mult/div; held high while it sits in EX.
- mem_branch_taken  input  1  branch in MEM resolved taken this cycle.
- pc_hold  output  1  PC keeps its value.
- ifid_hold  output  1  IF/ID register keeps its value.
- ifid_zero  output  1  IF/ID register loads zero.
- idex_hold  output  1  ID/EX register keeps its value.
- idex_zero  output  1  ID/EX register loads zero.
- exmem_zero  output  1  EX/MEM register loads zero.
- md_busy  output  1  FSM in BUSY state.
- md_done  output  1  one-cycle pulse: mult/div result valid, op advances at this edge.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Outputs are combinational from the current state, cnt and inputs. Registered state: FSM {RUN, BUSY} plus cnt[CW-1:0].
- Reset:
  - While rst=1: ifid_zero, idex_zero and exmem_zero = 1; all holds, md_busy and md_done = 0.
  - Next state: RUN, cnt=0. Reset mid-BUSY aborts the op with no md_done.
- Priority per cycle: rst > mem_branch_taken > mult/div sequencing > load-use.
- Branch flush (mem_branch_taken=1):
  - ifid_zero, idex_zero and exmem_zero = 1; all holds = 0.
  - If in BUSY, the younger mult/div op is squashed: state RUN, cnt=0, no md_done.
- Mult/div sequencing:
  - RUN and md_start=1: pc_hold, ifid_hold, idex_hold and exmem_zero = 1. Next state BUSY, cnt <= MD_CYCLES-2.
  - BUSY, cnt!=0: same holds and exmem_zero = 1; cnt decrements.
  - BUSY, cnt==0: no holds, md_done=1, exmem_zero=0. Next state RUN.
  - Total EX occupancy is exactly MD_CYCLES cycles, with MD_CYCLES-1 bubbles into MEM.
  - md_start is ignored while BUSY.
  - MD_CYCLES=2: exactly one BUSY cycle, with cnt==0.
- Load-use, evaluated only in RUN with md_start=0 and no branch:
  - Hazard when ex_memread=1 and ex_rt!=0 and (ex_rt==id_rs, or id_use_rt=1 and ex_rt==id_rt).
  - Response: pc_hold=1, ifid_hold=1, idex_zero=1. This is a single-cycle bubble and is purely combinational; no state change.
  - Register $0 never creates a hazard.
- Default when no event is active: all outputs 0.
- Never assert hold and zero on the same register in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles while md_start=1 -> all three zeros=1, holds=0; after release, state RUN and md_busy=0.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 -> pc_hold=ifid_hold=idex_zero=1 for one cycle.
  - ex_rt=0 -> no stall.
  - id_rt=8 with id_use_rt=0 -> no stall.
- Mult/div, MD_CYCLES=4: md_start high from cycle T.
  - Holds and exmem_zero=1 in cycles T..T+2.
  - md_done=1 and no holds in cycle T+3; md_busy=1 in T+1..T+3.
- MD_CYCLES=2: md_start at T -> stall only in T; md_done=1 in T+1.
- Branch abort: mem_branch_taken=1 in cycle T+1 of a busy op -> three zeros=1, holds=0.
  - md_busy=0 from T+2; md_done never pulses.
- Priority: load-use condition and mem_branch_taken together -> flush outputs only, pc_hold=0.
